// File: rtl/rs_station_pkg.sv
// Shared widths, opcodes and operand/CDB bundles for the reservation station.
// snoop() applies one cycle of CDB capture to a pending operand.
package rs_station_pkg;

    localparam int RS_SIZE = 16;
    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int IMM_W   = 32;
    localparam int OP_W    = 6;
    localparam int NICK_W  = 5;

    localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
    localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
    localparam logic [OP_W-1:0] OP_SUB  = 6'd2;
    localparam logic [OP_W-1:0] OP_AND  = 6'd3;
    localparam logic [OP_W-1:0] OP_OR   = 6'd4;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'd5;
    localparam logic [OP_W-1:0] OP_JAL  = 6'd6;
    localparam logic [OP_W-1:0] OP_JALR = 6'd7;

    typedef struct packed {
        logic              rdy;
        logic [DATA_W-1:0] dt;
        logic [NICK_W-1:0] nick;
    } opnd_t;

    typedef struct packed {
        logic              en;
        logic [NICK_W-1:0] nick;
        logic [DATA_W-1:0] dt;
    } cdb_t;

    // EX has priority if both buses carry the same tag.
    function automatic opnd_t snoop(opnd_t o, cdb_t ex, cdb_t slb);
        opnd_t r;
        r = o;
        if (!o.rdy) begin
            if (ex.en && ex.nick == o.nick) begin
                r.rdy = 1'b1;
                r.dt  = ex.dt;
            end else if (slb.en && slb.nick == o.nick) begin
                r.rdy = 1'b1;
                r.dt  = slb.dt;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_station_pick.sv
// Lowest-index priority encoders: first free slot and first ready slot.
// Ports: free_vec/ready_vec in; *_idx and *_found out (combinational).
module rs_pick
    import rs_station_pkg::*;
(
    input  logic [RS_SIZE-1:0] free_vec,
    input  logic [RS_SIZE-1:0] ready_vec,
    output logic [IDX_W-1:0]   free_idx,
    output logic               free_found,
    output logic [IDX_W-1:0]   ready_idx,
    output logic               ready_found
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        free_idx    = '0;
        free_found  = 1'b0;
        ready_idx   = '0;
        ready_found = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
            if (ready_vec[i]) begin
                ready_idx   = IDX_W'(i);
                ready_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds dispatched ops, snoops EX/SLB CDBs, issues one
// ready op per cycle to execute. Ports: clk/rst/rdy, iROB_clr flush,
// iDC_* dispatch + oDC_full, iEX_*/iSLB_* CDBs, oRS_* registered issue.
module rs_station
    import rs_station_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              iROB_clr,
    input  logic              iDC_en,
    input  logic [ADDR_W-1:0] iDC_pc,
    input  logic [OP_W-1:0]   iDC_op,
    input  logic [IMM_W-1:0]  iDC_imm,
    input  logic [NICK_W-1:0] iDC_rd_nick,
    input  logic              iDC_rs1_rdy,
    input  logic [DATA_W-1:0] iDC_rs1_dt,
    input  logic [NICK_W-1:0] iDC_rs1_nick,
    input  logic              iDC_rs2_rdy,
    input  logic [DATA_W-1:0] iDC_rs2_dt,
    input  logic [NICK_W-1:0] iDC_rs2_nick,
    output logic              oDC_full,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [DATA_W-1:0] iEX_dt,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [DATA_W-1:0] iSLB_dt,
    output logic              oRS_en,
    output logic [ADDR_W-1:0] oRS_pc,
    output logic [OP_W-1:0]   oRS_op,
    output logic [IMM_W-1:0]  oRS_imm,
    output logic [NICK_W-1:0] oRS_rd_nick,
    output logic [DATA_W-1:0] oRS_rs1_dt,
    output logic [DATA_W-1:0] oRS_rs2_dt
);

    logic [RS_SIZE-1:0] busy;
    logic [ADDR_W-1:0]  e_pc  [RS_SIZE];
    logic [OP_W-1:0]    e_op  [RS_SIZE];
    logic [IMM_W-1:0]   e_imm [RS_SIZE];
    logic [NICK_W-1:0]  e_rd  [RS_SIZE];
    opnd_t              e_rs1 [RS_SIZE];
    opnd_t              e_rs2 [RS_SIZE];

    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   pick_idx;
    logic               free_found;
    logic               pick_found;

    cdb_t  ex;
    cdb_t  slb;
    opnd_t dc_rs1;
    opnd_t dc_rs2;

    assign ex  = '{en: iEX_en, nick: iEX_nick, dt: iEX_dt};
    assign slb = '{en: iSLB_en, nick: iSLB_nick, dt: iSLB_dt};

    // Dispatch bypass: catch a broadcast that lands in the dispatch cycle.
    assign dc_rs1 = snoop('{rdy: iDC_rs1_rdy, dt: iDC_rs1_dt,
                            nick: iDC_rs1_nick}, ex, slb);
    assign dc_rs2 = snoop('{rdy: iDC_rs2_rdy, dt: iDC_rs2_dt,
                            nick: iDC_rs2_nick}, ex, slb);

    // Selection looks only at registered state, so a CDB value is
    // never issued in the cycle it is broadcast.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = busy[i] & e_rs1[i].rdy & e_rs2[i].rdy;
        end
    end

    assign free_vec = ~busy;
    assign oDC_full = ~free_found;

    rs_pick u_pick (
        .free_vec    (free_vec),
        .ready_vec   (ready_vec),
        .free_idx    (free_idx),
        .free_found  (free_found),
        .ready_idx   (pick_idx),
        .ready_found (pick_found)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                e_pc[i]  <= '0;
                e_op[i]  <= '0;
                e_imm[i] <= '0;
                e_rd[i]  <= '0;
                e_rs1[i] <= '0;
                e_rs2[i] <= '0;
            end
            oRS_en      <= 1'b0;
            oRS_pc      <= '0;
            oRS_op      <= '0;
            oRS_imm     <= '0;
            oRS_rd_nick <= '0;
            oRS_rs1_dt  <= '0;
            oRS_rs2_dt  <= '0;
        end else if (rdy) begin
            if (iROB_clr) begin
                busy   <= '0;
                oRS_en <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        e_rs1[i] <= snoop(e_rs1[i], ex, slb);
                        e_rs2[i] <= snoop(e_rs2[i], ex, slb);
                    end
                end
                if (pick_found) begin
                    oRS_en         <= 1'b1;
                    oRS_pc         <= e_pc[pick_idx];
                    oRS_op         <= e_op[pick_idx];
                    oRS_imm        <= e_imm[pick_idx];
                    oRS_rd_nick    <= e_rd[pick_idx];
                    oRS_rs1_dt     <= e_rs1[pick_idx].dt;
                    oRS_rs2_dt     <= e_rs2[pick_idx].dt;
                    busy[pick_idx] <= 1'b0;
                end else begin
                    oRS_en <= 1'b0;
                end
                // Free slot is never busy, so it cannot collide with issue.
                if (iDC_en && free_found) begin
                    busy[free_idx]  <= 1'b1;
                    e_pc[free_idx]  <= iDC_pc;
                    e_op[free_idx]  <= iDC_op;
                    e_imm[free_idx] <= iDC_imm;
                    e_rd[free_idx]  <= iDC_rd_nick;
                    e_rs1[free_idx] <= dc_rs1;
                    e_rs2[free_idx] <= dc_rs2;
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed scenarios plus random
// traffic against a slot-array reference model.
module tb_rs_station;
    import rs_station_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rdy, clr;
    logic              dc_en;
    logic [ADDR_W-1:0] dc_pc;
    logic [OP_W-1:0]   dc_op;
    logic [IMM_W-1:0]  dc_imm;
    logic [NICK_W-1:0] dc_rd;
    logic              dc_r1, dc_r2;
    logic [DATA_W-1:0] dc_d1, dc_d2;
    logic [NICK_W-1:0] dc_n1, dc_n2;
    logic              full;
    logic              ex_en, slb_en;
    logic [NICK_W-1:0] ex_nick, slb_nick;
    logic [DATA_W-1:0] ex_dt, slb_dt;
    logic              o_en;
    logic [ADDR_W-1:0] o_pc;
    logic [OP_W-1:0]   o_op;
    logic [IMM_W-1:0]  o_imm;
    logic [NICK_W-1:0] o_rd;
    logic [DATA_W-1:0] o_d1, o_d2;

    rs_station dut (
        .clk(clk), .rst(rst), .rdy(rdy), .iROB_clr(clr),
        .iDC_en(dc_en), .iDC_pc(dc_pc), .iDC_op(dc_op),
        .iDC_imm(dc_imm), .iDC_rd_nick(dc_rd),
        .iDC_rs1_rdy(dc_r1), .iDC_rs1_dt(dc_d1), .iDC_rs1_nick(dc_n1),
        .iDC_rs2_rdy(dc_r2), .iDC_rs2_dt(dc_d2), .iDC_rs2_nick(dc_n2),
        .oDC_full(full),
        .iEX_en(ex_en), .iEX_nick(ex_nick), .iEX_dt(ex_dt),
        .iSLB_en(slb_en), .iSLB_nick(slb_nick), .iSLB_dt(slb_dt),
        .oRS_en(o_en), .oRS_pc(o_pc), .oRS_op(o_op), .oRS_imm(o_imm),
        .oRS_rd_nick(o_rd), .oRS_rs1_dt(o_d1), .oRS_rs2_dt(o_d2)
    );

    typedef struct {
        bit                busy;
        logic [ADDR_W-1:0] pc;
        logic [OP_W-1:0]   op;
        logic [IMM_W-1:0]  imm;
        logic [NICK_W-1:0] rd;
        bit                r1, r2;
        logic [DATA_W-1:0] d1, d2;
        logic [NICK_W-1:0] n1, n2;
    } ment_t;

    ment_t             m [RS_SIZE];
    bit                e_en;
    logic [ADDR_W-1:0] e_pc;
    logic [OP_W-1:0]   e_op;
    logic [IMM_W-1:0]  e_imm;
    logic [NICK_W-1:0] e_rd;
    logic [DATA_W-1:0] e_d1, e_d2;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_full();
        for (int i = 0; i < RS_SIZE; i++)
            if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit cdb(input logic [NICK_W-1:0] n,
                               output logic [DATA_W-1:0] d);
        d = '0;
        if (ex_en && ex_nick == n) begin
            d = ex_dt;
            return 1'b1;
        end
        if (slb_en && slb_nick == n) begin
            d = slb_dt;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
        e_en = 0; e_pc = '0; e_op = '0; e_imm = '0;
        e_rd = '0; e_d1 = '0; e_d2 = '0;
    endtask

    // Next-state of the station for the inputs currently driven.
    task automatic model_edge();
        ment_t nx [RS_SIZE];
        int iss, fr;
        logic [DATA_W-1:0] v;
        if (!rdy) return;
        if (clr) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            e_en = 0;
            return;
        end
        nx = m;
        iss = -1;
        fr = -1;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (iss < 0 && m[i].busy && m[i].r1 && m[i].r2) iss = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        if (iss >= 0) begin
            e_en = 1; e_pc = m[iss].pc; e_op = m[iss].op;
            e_imm = m[iss].imm; e_rd = m[iss].rd;
            e_d1 = m[iss].d1; e_d2 = m[iss].d2;
            nx[iss].busy = 1'b0;
        end else begin
            e_en = 0;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (m[i].busy && !m[i].r1 && cdb(m[i].n1, v)) begin
                nx[i].r1 = 1; nx[i].d1 = v;
            end
            if (m[i].busy && !m[i].r2 && cdb(m[i].n2, v)) begin
                nx[i].r2 = 1; nx[i].d2 = v;
            end
        end
        if (dc_en && fr >= 0) begin
            nx[fr].busy = 1; nx[fr].pc = dc_pc; nx[fr].op = dc_op;
            nx[fr].imm = dc_imm; nx[fr].rd = dc_rd;
            nx[fr].r1 = dc_r1; nx[fr].d1 = dc_d1; nx[fr].n1 = dc_n1;
            nx[fr].r2 = dc_r2; nx[fr].d2 = dc_d2; nx[fr].n2 = dc_n2;
            if (!dc_r1 && cdb(dc_n1, v)) begin
                nx[fr].r1 = 1; nx[fr].d1 = v;
            end
            if (!dc_r2 && cdb(dc_n2, v)) begin
                nx[fr].r2 = 1; nx[fr].d2 = v;
            end
        end
        m = nx;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".en"}, 64'(o_en), 64'(e_en));
        chk({tag, ".pc"}, 64'(o_pc), 64'(e_pc));
        chk({tag, ".op"}, 64'(o_op), 64'(e_op));
        chk({tag, ".imm"}, 64'(o_imm), 64'(e_imm));
        chk({tag, ".rd"}, 64'(o_rd), 64'(e_rd));
        chk({tag, ".d1"}, 64'(o_d1), 64'(e_d1));
        chk({tag, ".d2"}, 64'(o_d2), 64'(e_d2));
        chk({tag, ".full"}, 64'(full), 64'(m_full()));
    endtask

    task automatic cyc();
        if (rst) model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic idle();
        rdy = 1; clr = 0; dc_en = 0; ex_en = 0; slb_en = 0;
    endtask

    task automatic disp(input logic [ADDR_W-1:0] pc,
                        input logic [OP_W-1:0] op,
                        input logic [NICK_W-1:0] rd,
                        input logic r1, input logic [DATA_W-1:0] d1,
                        input logic [NICK_W-1:0] n1,
                        input logic r2, input logic [DATA_W-1:0] d2,
                        input logic [NICK_W-1:0] n2);
        dc_en = 1; dc_pc = pc; dc_op = op; dc_imm = $urandom();
        dc_rd = rd; dc_r1 = r1; dc_d1 = d1; dc_n1 = n1;
        dc_r2 = r2; dc_d2 = d2; dc_n2 = n2;
    endtask

    always @(posedge clk) begin
        if (rst && rdy && dc_en)
            assert (!full) else $error("FAIL protocol: dispatch while full");
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 0;
        idle();
        disp('0, '0, '0, 0, '0, '0, 0, '0, '0);
        dc_en = 0;
        ex_nick = '0; ex_dt = '0; slb_nick = '0; slb_dt = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        chk("reset.en", 64'(o_en), 64'(0));
        chk("reset.full", 64'(full), 64'(0));
        rst = 1;

        // Ready-at-dispatch issue latency.
        disp(32'h100, OP_ADD, 5'd3, 1, 32'd5, '0, 1, 32'd7, '0);
        cyc();
        idle();
        cyc();
        chk("t2.en", 64'(o_en), 64'(1));
        chk("t2.op", 64'(o_op), 64'(OP_ADD));
        chk("t2.d1", 64'(o_d1), 64'(5));
        chk("t2.d2", 64'(o_d2), 64'(7));
        chk("t2.rd", 64'(o_rd), 64'(3));
        cyc();
        chk("t2.drop", 64'(o_en), 64'(0));

        // Wakeup via EX then via SLB.
        for (int k = 0; k < 2; k++) begin
            disp(32'h200, OP_SUB, 5'd4, 0, '0, 5'd2, 1, 32'd1, '0);
            cyc();
            idle();
            cyc();
            chk("t3.wait", 64'(o_en), 64'(0));
            if (k == 0) begin
                ex_en = 1; ex_nick = 5'd2; ex_dt = 32'h10;
            end else begin
                slb_en = 1; slb_nick = 5'd2; slb_dt = 32'h10;
            end
            cyc();
            chk("t3.wake", 64'(o_en), 64'(0));
            idle();
            cyc();
            chk("t3.en", 64'(o_en), 64'(1));
            chk("t3.d1", 64'(o_d1), 64'(32'h10));
            chk("t3.d2", 64'(o_d2), 64'(1));
            cyc();
        end

        // Dispatch bypass.
        disp(32'h300, OP_AND, 5'd6, 0, '0, 5'd5, 1, 32'd2, '0);
        ex_en = 1; ex_nick = 5'd5; ex_dt = 32'd9;
        cyc();
        chk("t4.wait", 64'(o_en), 64'(0));
        idle();
        cyc();
        chk("t4.en", 64'(o_en), 64'(1));
        chk("t4.d1", 64'(o_d1), 64'(9));
        cyc();

        // Fill, wake all, drain in index order with a freeze.
        for (int i = 0; i < RS_SIZE; i++) begin
            disp(32'(i), OP_OR, 5'(i), 0, '0, 5'd1, 1, 32'(i + 100), '0);
            cyc();
        end
        idle();
        chk("t5.full", 64'(full), 64'(1));
        ex_en = 1; ex_nick = 5'd1; ex_dt = 32'h55;
        cyc();
        chk("t5.wake", 64'(o_en), 64'(0));
        idle();
        for (int i = 0; i < RS_SIZE; i++) begin
            if (i == 5) begin
                rdy = 0;
                repeat (3) begin
                    cyc();
                    chk("t5.frz_en", 64'(o_en), 64'(1));
                    chk("t5.frz_pc", 64'(o_pc), 64'(4));
                end
                rdy = 1;
            end
            cyc();
            chk("t5.en", 64'(o_en), 64'(1));
            chk("t5.pc", 64'(o_pc), 64'(i));
            chk("t5.d1", 64'(o_d1), 64'(32'h55));
            chk("t5.d2", 64'(o_d2), 64'(i + 100));
            if (i == 0) chk("t5.unfull", 64'(full), 64'(0));
        end
        cyc();
        chk("t5.end", 64'(o_en), 64'(0));

        // Flush drops busy entries and the same-edge dispatch.
        for (int i = 0; i < 4; i++) begin
            disp(32'(i), OP_BEQ, 5'd9, 0, '0, 5'd7, 1, '0, '0);
            cyc();
        end
        disp(32'h400, OP_JAL, 5'd8, 1, 32'd1, '0, 1, 32'd2, '0);
        clr = 1;
        cyc();
        chk("t6.en", 64'(o_en), 64'(0));
        chk("t6.full", 64'(full), 64'(0));
        idle();
        ex_en = 1; ex_nick = 5'd7; ex_dt = 32'd3;
        cyc();
        idle();
        repeat (3) begin
            cyc();
            chk("t6.after", 64'(o_en), 64'(0));
        end

        // Asynchronous reset between edges.
        for (int i = 0; i < 3; i++) begin
            disp(32'(i), OP_ADD, 5'd1, 0, '0, 5'd6, 1, '0, '0);
            cyc();
        end
        idle();
        #1 rst = 0;
        #1;
        model_reset();
        chk("t1.en", 64'(o_en), 64'(0));
        chk("t1.full", 64'(full), 64'(0));
        chk("t1.pc", 64'(o_pc), 64'(0));
        #1 rst = 1;
        ex_en = 1; ex_nick = 5'd6; ex_dt = 32'd1;
        cyc();
        idle();
        repeat (3) begin
            cyc();
            chk("t1.noiss", 64'(o_en), 64'(0));
        end

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 39) == 0);
            dc_en = !m_full() && ($urandom_range(0, 9) < 6);
            dc_pc = $urandom();
            dc_op = OP_W'($urandom_range(0, 7));
            dc_imm = $urandom();
            dc_rd = NICK_W'($urandom_range(0, 31));
            dc_r1 = ($urandom_range(0, 1) == 1);
            dc_r2 = ($urandom_range(0, 1) == 1);
            dc_d1 = $urandom();
            dc_d2 = $urandom();
            dc_n1 = NICK_W'($urandom_range(0, 7));
            dc_n2 = NICK_W'($urandom_range(0, 7));
            ex_en = ($urandom_range(0, 9) < 4);
            ex_nick = NICK_W'($urandom_range(0, 7));
            ex_dt = $urandom();
            slb_en = ($urandom_range(0, 9) < 3);
            slb_nick = NICK_W'($urandom_range(0, 7));
            slb_dt = $urandom();
            if (ex_en && slb_en && ex_nick == slb_nick) slb_en = 0;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
